// File: rtl/bias_stream_gen_if.sv
// Downstream ap_fifo-style write channel carrying bias words.
interface bias_stream_gen_if #(
    parameter int unsigned COEFF_WIDTH = 16
);
    logic [COEFF_WIDTH-1:0] din;
    logic                   full_n;
    logic                   write;

    modport master (output din, output write, input full_n);
    modport slave  (input din, input write, output full_n);
endinterface

// File: rtl/bias_stream_gen.sv
// Streams a layer's bias ROM into a FIFO channel, with per-word repetition
// and multi-pass replay under ap_start/ap_done control.
module bias_stream_gen #(
    parameter int unsigned COEFF_WIDTH = 16,
    parameter int unsigned NUM_KERNELS = 16,
    parameter int unsigned CNT_WIDTH   = 16,
    // ROM image, word k at bits [k*COEFF_WIDTH +: COEFF_WIDTH]
    parameter logic [NUM_KERNELS*COEFF_WIDTH-1:0] ROM_INIT = '0
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 ap_start,
    output logic                 ap_done,
    output logic                 ap_ready,
    output logic                 ap_idle,
    input  logic [CNT_WIDTH-1:0] num_passes,
    input  logic [CNT_WIDTH-1:0] rep_each,
    bias_stream_gen_if.master    output_V
);
    localparam int unsigned   AW       = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_KERNELS - 1);

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DONE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_passes, w_passes_nxt;
    logic [CNT_WIDTH-1:0]   r_rep_max, w_rep_max_nxt;
    logic [CNT_WIDTH-1:0]   r_rep, w_rep_nxt;
    logic [CNT_WIDTH-1:0]   r_pass, w_pass_nxt;
    logic [AW-1:0]          r_idx, w_idx_nxt;
    logic [AW-1:0]          w_rom_addr;
    logic                   w_rom_ce;
    logic [COEFF_WIDTH-1:0] w_rom_word;
    logic [COEFF_WIDTH-1:0] r_rom_q;
    logic                   r_done, r_idle;
    logic                   w_xfer, w_last_rep, w_last_idx, w_last_pass;

    assign w_xfer      = (r_state == S_RUN) && output_V.full_n;
    assign w_last_rep  = (r_rep == r_rep_max - CNT_WIDTH'(1));
    assign w_last_idx  = (r_idx == LAST_IDX);
    assign w_last_pass = (r_pass == r_passes - CNT_WIDTH'(1));
    assign w_rom_word  = ROM_INIT[32'(w_rom_addr) * COEFF_WIDTH +: COEFF_WIDTH];

    assign output_V.din   = r_rom_q;
    assign output_V.write = w_xfer;
    assign ap_done        = r_done;
    assign ap_ready       = r_done;
    assign ap_idle        = r_idle;

    // State, counters and synchronous ROM output register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state   <= S_IDLE;
            r_passes  <= '0;
            r_rep_max <= '0;
            r_rep     <= '0;
            r_pass    <= '0;
            r_idx     <= '0;
            r_rom_q   <= '0;
            r_done    <= 1'b0;
            r_idle    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_passes  <= w_passes_nxt;
            r_rep_max <= w_rep_max_nxt;
            r_rep     <= w_rep_nxt;
            r_pass    <= w_pass_nxt;
            r_idx     <= w_idx_nxt;
            if (w_rom_ce) r_rom_q <= w_rom_word;
            r_done    <= (w_state_nxt == S_DONE);
            r_idle    <= (w_state_nxt == S_IDLE);
        end
    end

    // Next state; the ROM is read ahead on the last repeat so writes stay back-to-back
    always_comb begin
        w_state_nxt   = r_state;
        w_passes_nxt  = r_passes;
        w_rep_max_nxt = r_rep_max;
        w_rep_nxt     = r_rep;
        w_pass_nxt    = r_pass;
        w_idx_nxt     = r_idx;
        w_rom_ce      = 1'b0;
        w_rom_addr    = r_idx;
        case (r_state)
            S_IDLE: begin
                if (ap_start) begin
                    w_passes_nxt  = num_passes;
                    w_rep_max_nxt = (rep_each == '0) ? CNT_WIDTH'(1) : rep_each;
                    w_rep_nxt     = '0;
                    w_pass_nxt    = '0;
                    w_idx_nxt     = '0;
                    w_state_nxt   = (num_passes == '0) ? S_DONE : S_PRIME;
                end
            end
            S_PRIME: begin
                w_rom_ce    = 1'b1;
                w_rom_addr  = '0;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_xfer) begin
                    if (!w_last_rep) begin
                        w_rep_nxt = r_rep + CNT_WIDTH'(1);
                    end else begin
                        w_rep_nxt = '0;
                        if (!w_last_idx) begin
                            w_idx_nxt  = r_idx + AW'(1);
                            w_rom_ce   = 1'b1;
                            w_rom_addr = r_idx + AW'(1);
                        end else if (!w_last_pass) begin
                            w_idx_nxt  = '0;
                            w_pass_nxt = r_pass + CNT_WIDTH'(1);
                            w_rom_ce   = 1'b1;
                            w_rom_addr = '0;
                        end else begin
                            w_idx_nxt   = '0;
                            w_state_nxt = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end
endmodule
